// File: rtl/vscale_csr_port_arbiter.sv
// vscale_csr_port_arbiter
//
// Shares the single CSR-file access port between the pipeline's CSR
// instructions (core) and HTIF PCR requests (host). The core normally owns the
// port. A pending host request takes the port when the core is idle, or when
// the request has already lost MAX_HOST_WAIT consecutive cycles to the core.
//
// Handshake semantics: a host request transfers on a rising clk edge where
// htif_req_valid && htif_req_ready. A response transfers on a rising edge where
// htif_resp_valid && htif_resp_ready. Once htif_resp_valid rises,
// htif_resp_valid and htif_resp_data stay stable until that transfer happens.
// The host may raise htif_req_valid without waiting for htif_req_ready.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   core_cmd/addr/wdata          core CSR access (core_cmd[2] = access valid)
//   core_rdata/illegal/stall     core result; stall = access not performed
//   htif_req_*                   host request channel (valid/ready)
//   htif_resp_*                  host response channel (valid/ready)
//   csr_addr/cmd/wdata           command to the CSR file
//   csr_rdata/illegal            CSR file result (rdata combinational in addr)
//   state_dbg                    none; FSM state is the internal 'state' signal

module vscale_csr_port_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int XLEN          = 32,
  parameter int HTIF_W        = 64,
  parameter int MAX_HOST_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        core_cmd,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [XLEN-1:0]   core_wdata,
  output logic [XLEN-1:0]   core_rdata,
  output logic              core_illegal,
  output logic              core_stall,
  input  logic              htif_req_valid,
  output logic              htif_req_ready,
  input  logic              htif_req_rw,
  input  logic [ADDR_W-1:0] htif_req_addr,
  input  logic [HTIF_W-1:0] htif_req_data,
  output logic              htif_resp_valid,
  input  logic              htif_resp_ready,
  output logic [HTIF_W-1:0] htif_resp_data,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [2:0]        csr_cmd,
  output logic [XLEN-1:0]   csr_wdata,
  input  logic [XLEN-1:0]   csr_rdata,
  input  logic              csr_illegal
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_HOST_ACC  = 2'd1;
  localparam logic [1:0] S_HOST_RESP = 2'd2;

  localparam logic [2:0] CMD_NONE  = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b100;
  localparam logic [2:0] CMD_WRITE = 3'b101;

  localparam logic [3:0] MAX_WAIT = 4'(MAX_HOST_WAIT);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [3:0]        wait_cnt;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_data;
  logic [XLEN-1:0]   resp_data;

  logic core_req;
  logic host_win;
  logic host_take;
  logic core_own;
  logic host_acc;

  // Only the low XLEN bits of host write data reach the CSR file.
  logic unused_req_data_hi;
  assign unused_req_data_hi = ^htif_req_data[HTIF_W-1:XLEN];

  assign core_req  = core_cmd[2];
  assign host_win  = !core_req || (wait_cnt == MAX_WAIT);
  assign host_take = (state == S_IDLE) && htif_req_valid && host_win && !reset;
  // The core keeps the port in IDLE unless the host takes it this cycle, and
  // always has it while the host is only waiting on its response.
  assign core_own  = core_req &&
                     (((state == S_IDLE) && !host_take) || (state == S_HOST_RESP));
  // Gated by reset so a latched host write is dropped, not performed.
  assign host_acc  = (state == S_HOST_ACC) && !reset;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (host_take) state_next = S_HOST_ACC;
      S_HOST_ACC:  state_next = S_HOST_RESP;
      S_HOST_RESP: if (htif_resp_ready) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    csr_addr        = core_addr;
    csr_cmd         = CMD_NONE;
    csr_wdata       = core_wdata;
    core_rdata      = '0;
    core_illegal    = 1'b0;
    core_stall      = core_req && !core_own;
    htif_req_ready  = (state == S_IDLE) && host_win && !reset;
    htif_resp_valid = (state == S_HOST_RESP) && !reset;
    htif_resp_data  = {{(HTIF_W-XLEN){1'b0}}, resp_data};
    if (host_acc) begin
      csr_addr  = req_addr;
      csr_cmd   = req_rw ? CMD_WRITE : CMD_READ;
      csr_wdata = req_data;
    end else if (core_own) begin
      csr_cmd      = core_cmd;
      core_rdata   = csr_rdata;
      core_illegal = csr_illegal;
    end
  end

  // Host request latch, response register and starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      req_rw    <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      resp_data <= '0;
    end else begin
      if (host_take) begin
        wait_cnt <= '0;
        req_rw   <= htif_req_rw;
        req_addr <= htif_req_addr;
        req_data <= htif_req_data[XLEN-1:0];
      end else if ((state == S_IDLE) && htif_req_valid && core_own &&
                   (wait_cnt != MAX_WAIT)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      // csr_rdata is combinational in csr_addr, so for a host write this
      // captures the value before the write lands.
      if (state == S_HOST_ACC) begin
        resp_data <= csr_rdata;
      end
    end
  end

endmodule
